store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 158 +++++++++++++++
 tb/tb_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Read-modify-write store unit: SW writes directly, SH/SB read the word, merge the lane, write back.
// Optional alignment fault checking is enabled by defining STORE_ALIGN_CHECK_EN.
module store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign_err,
  output logic [2:0]  o_dbg_state
);

  // Handshake: start is a level sampled only while busy=0 (IDLE); any value
  // of start while busy=1 is ignored. done is a single-cycle pulse and the
  // unit accepts a new start in the very next cycle.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] TYPE_SW = 2'b00;
  localparam logic [1:0] TYPE_SH = 2'b01;
  localparam logic [1:0] TYPE_SB = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr_q;
  logic [31:0] r_data_q;
  logic [1:0]  r_type_q;
  logic [31:0] r_merged;
  logic [31:0] w_merged;
  logic        w_accept;
  logic        w_misaligned;

  assign w_accept = (r_state == S_IDLE) && start;

`ifdef STORE_ALIGN_CHECK_EN
  logic r_misalign;

  assign w_misaligned = ((store_type == TYPE_SH) && addr[0]) ||
                        ((store_type == TYPE_SW) && (addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (w_accept) begin
      r_misalign <= w_misaligned;
    end
  end

  assign misalign_err = (r_state == S_DONE) && r_misalign;
`else
  assign w_misaligned = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_misaligned) begin
            w_next = S_DONE;
          end else begin
            case (store_type)
              TYPE_SW: w_next = S_WRITE;
              TYPE_SH: w_next = S_READ;
              TYPE_SB: w_next = S_READ;
              default: w_next = S_DONE;
            endcase
          end
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_q <= 32'h0;
      r_data_q <= 32'h0;
      r_type_q <= 2'b00;
    end else if (w_accept) begin
      r_addr_q <= addr;
      r_data_q <= store_data;
      r_type_q <= store_type;
    end
  end

  // Lane merge: only the addressed byte/halfword of the read word is replaced.
  always_comb begin
    w_merged = mem_rdata;
    if (r_type_q == TYPE_SB) begin
      case (r_addr_q[1:0])
        2'd0:    w_merged[7:0]   = r_data_q[7:0];
        2'd1:    w_merged[15:8]  = r_data_q[7:0];
        2'd2:    w_merged[23:16] = r_data_q[7:0];
        default: w_merged[31:24] = r_data_q[7:0];
      endcase
    end else if (r_type_q == TYPE_SH) begin
      if (r_addr_q[1]) begin
        w_merged[31:16] = r_data_q[15:0];
      end else begin
        w_merged[15:0]  = r_data_q[15:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_merged <= 32'h0;
    end else if (r_state == S_WAIT) begin
      r_merged <= w_merged;
    end
  end

  // Moore outputs decoded from registered state
  always_comb begin
    mem_addr  = {r_addr_q[31:2], 2'b00};
    mem_wdata = 32'h0;
    mem_wr    = 1'b0;
    busy      = (r_state != S_IDLE);
    done      = (r_state == S_DONE);
    if (r_state == S_WRITE) begin
      mem_wr    = 1'b1;
      mem_wdata = (r_type_q == TYPE_SW) ? r_data_q : r_merged;
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_store_unit.sv
// Directed, table-driven bench for store_unit plus hand-written multi-cycle sequences.
// Expectations follow STORE_ALIGN_CHECK_EN the same way the design does.
module tb_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misalign_err;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          exp_wr;
    int          exp_wr_cyc;
    int          exp_done_cyc;
    logic [31:0] exp_maddr;
    logic [31:0] exp_wdata;
    logic        exp_mis;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .store_type   (store_type),
    .addr         (addr),
    .store_data   (store_data),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr       (mem_wr),
    .busy         (busy),
    .done         (done),
    .misalign_err (misalign_err),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int wr,
                         input int wc, input int dc, input logic [31:0] ma,
                         input logic [31:0] wd, input logic mis);
    vecs[i].typ = t;        vecs[i].addr = a;       vecs[i].data = d;
    vecs[i].rdata = rd;     vecs[i].exp_wr = wr;    vecs[i].exp_wr_cyc = wc;
    vecs[i].exp_done_cyc = dc; vecs[i].exp_maddr = ma;
    vecs[i].exp_wdata = wd; vecs[i].exp_mis = mis;
  endtask

  // driver: one store, observed for six cycles after the start edge
  task automatic run_vec(input int idx, input vec_t v);
    int wr_cnt = 0;
    int wr_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int busy_bad = 0;
    int wz_bad = 0;
    int mis_bad = 0;
    logic mis_seen = 1'b0;
    logic [31:0] wd = 32'h0;
    logic [31:0] wa = 32'h0;
    logic [31:0] e;
    if (v.exp_wr != 0) exp_q.push_back(v.exp_wdata);
    @(negedge clk);
    start = 1'b1; store_type = v.typ; addr = v.addr;
    store_data = v.data; mem_rdata = v.rdata;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_wr) begin
        wr_cnt++; wr_cyc = c; wd = mem_wdata; wa = mem_addr;
      end else if (mem_wdata !== 32'h0) begin
        wz_bad++;
      end
      if (done) begin
        done_cnt++; done_cyc = c;
        if (misalign_err) mis_seen = 1'b1;
      end else if (misalign_err) begin
        mis_bad++;
      end
      if (busy !== (c <= v.exp_done_cyc)) busy_bad++;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d write count", idx), wr_cnt, v.exp_wr);
    if (v.exp_wr != 0) begin
      chk($sformatf("v%0d write cycle", idx), wr_cyc, v.exp_wr_cyc);
      chk($sformatf("v%0d mem_addr", idx), wa, v.exp_maddr);
      e = exp_q.pop_front();
      chk($sformatf("v%0d mem_wdata", idx), wd, e);
    end
    chk($sformatf("v%0d done cycle", idx), done_cyc, v.exp_done_cyc);
    chk($sformatf("v%0d done count", idx), done_cnt, 1);
    chk($sformatf("v%0d misalign_err", idx), {31'h0, mis_seen}, {31'h0, v.exp_mis});
    chk($sformatf("v%0d stray misalign", idx), mis_bad, 0);
    chk($sformatf("v%0d busy profile", idx), busy_bad, 0);
    chk($sformatf("v%0d wdata zero off-write", idx), wz_bad, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " mem_wr"}, {31'h0, mem_wr}, 32'h0);
    chk({tag, " busy"}, {31'h0, busy}, 32'h0);
    chk({tag, " done"}, {31'h0, done}, 32'h0);
    chk({tag, " misalign_err"}, {31'h0, misalign_err}, 32'h0);
    chk({tag, " mem_addr"}, mem_addr, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    int wr_cnt;
    int done_cnt;
    logic [31:0] wd;

    start = 1'b0; store_type = 2'b00; addr = 32'h0;
    store_data = 32'h0; mem_rdata = 32'h0;

    // vector table: type, addr, data, rdata, writes, wr cycle, done cycle, mem_addr, wdata, misalign
    set_vec(0,  2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1, 1, 2, 32'h10, 32'hDEAD_BEEF, 1'b0);
    set_vec(1,  2'b10, 32'h0000_0023, 32'h0000_00AB, 32'h1122_3344, 1, 3, 4, 32'h20, 32'hAB22_3344, 1'b0);
    set_vec(2,  2'b01, 32'h0000_0012, 32'h0000_CAFE, 32'h1122_3344, 1, 3, 4, 32'h10, 32'hCAFE_3344, 1'b0);
    set_vec(3,  2'b01, 32'h0000_0010, 32'h0000_CAFE, 32'h1122_3344, 1, 3, 4, 32'h10, 32'h1122_CAFE, 1'b0);
    set_vec(4,  2'b10, 32'h0000_0020, 32'hFFFF_FF5A, 32'h1122_3344, 1, 3, 4, 32'h20, 32'h1122_335A, 1'b0);
    set_vec(5,  2'b10, 32'h0000_0021, 32'h0000_0077, 32'hAABB_CCDD, 1, 3, 4, 32'h20, 32'hAABB_77DD, 1'b0);
    set_vec(6,  2'b10, 32'h0000_0022, 32'h0000_0001, 32'hAABB_CCDD, 1, 3, 4, 32'h20, 32'hAA01_CCDD, 1'b0);
    set_vec(7,  2'b11, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 1, 32'h0,  32'h0,         1'b0);
    set_vec(8,  2'b00, 32'hFFFF_FFFC, 32'h8000_0001, 32'h0,         1, 1, 2, 32'hFFFF_FFFC, 32'h8000_0001, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
    set_vec(9,  2'b00, 32'h0000_0013, 32'h1234_5678, 32'h0,         0, 0, 1, 32'h0,  32'h0,         1'b1);
    set_vec(10, 2'b01, 32'h0000_0011, 32'h0000_BEEF, 32'h1122_3344, 0, 0, 1, 32'h0,  32'h0,         1'b1);
`else
    set_vec(9,  2'b00, 32'h0000_0013, 32'h1234_5678, 32'h0,         1, 1, 2, 32'h10, 32'h1234_5678, 1'b0);
    set_vec(10, 2'b01, 32'h0000_0011, 32'h0000_BEEF, 32'h1122_3344, 1, 3, 4, 32'h10, 32'h1122_BEEF, 1'b0);
`endif

    // reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post-reset idle");

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // start held during an SB, then a new SW started in the IDLE cycle after DONE
    wr_cnt = 0; done_cnt = 0; wd = 32'h0;
    exp_q.push_back(32'hAB22_3344);
    @(negedge clk);
    start = 1'b1; store_type = 2'b10; addr = 32'h23;
    store_data = 32'hAB; mem_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    for (int c = 1; c <= 5; c++) begin
      if (mem_wr) begin wr_cnt++; wd = mem_wdata; end
      if (done) done_cnt++;
      if (c == 5) chk("spam idle busy", {31'h0, busy}, 32'h0);
      if (c <= 3) begin
        start = 1'b1; store_type = 2'b00; addr = 32'h0; store_data = 32'h5555_5555;
      end else if (c == 4) begin
        start = 1'b0;
      end else begin
        start = 1'b1; store_type = 2'b00; addr = 32'h30; store_data = 32'hCAFE_F00D;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("spam write count", wr_cnt, 1);
    chk("spam done count", done_cnt, 1);
    chk("spam merged wdata", wd, exp_q.pop_front());
    chk("restart mem_wr", {31'h0, mem_wr}, 32'h1);
    chk("restart mem_addr", mem_addr, 32'h30);
    chk("restart mem_wdata", mem_wdata, 32'hCAFE_F00D);
    @(posedge clk); #1;
    chk("restart done", {31'h0, done}, 32'h1);
    @(posedge clk); #1;

    // reset asserted during WAIT aborts the store
    @(negedge clk);
    start = 1'b1; store_type = 2'b10; addr = 32'h21;
    store_data = 32'h99; mem_rdata = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    chk("pre-abort busy", {31'h0, busy}, 32'h1);
    reset = 1'b0;
    #1;
    chk_idle_outputs("abort");
    wr_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (mem_wr) wr_cnt++;
    end
    chk("abort no write", wr_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    run_vec(100, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
